// File: rtl/conware_pkg.sv
// Shared types and the Life rule for the conware life engine.
package conware_pkg;

  typedef enum logic [1:0] {
    ST_LOAD    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  localparam int NCNT_W = 4;

  function automatic logic life_rule(input logic alive, input logic [NCNT_W-1:0] n);
    return (n == NCNT_W'(3)) || (alive && (n == NCNT_W'(2)));
  endfunction

endpackage

// File: rtl/conware_row_next.sv
// Combinational next-generation row: one cell of output per column from three input rows.
module conware_row_next
  import conware_pkg::*;
#(
  parameter int GRID_W = 32,
  parameter bit WRAP   = 1'b1
) (
  input  logic [GRID_W-1:0] above,
  input  logic [GRID_W-1:0] mid,
  input  logic [GRID_W-1:0] below,
  output logic [GRID_W-1:0] row_next
);

  for (genvar c = 0; c < GRID_W; c++) begin : g_col
    localparam int CL    = (c == 0) ? GRID_W - 1 : c - 1;
    localparam int CR    = (c == GRID_W - 1) ? 0 : c + 1;
    localparam bit HAS_L = WRAP || (c != 0);
    localparam bit HAS_R = WRAP || (c != GRID_W - 1);

    logic l_a, r_a, l_m, r_m, l_b, r_b;
    logic [NCNT_W-1:0] n;

    // Columns beyond the edge read as dead unless the grid wraps.
    assign l_a = HAS_L ? above[CL] : 1'b0;
    assign r_a = HAS_R ? above[CR] : 1'b0;
    assign l_m = HAS_L ? mid[CL]   : 1'b0;
    assign r_m = HAS_R ? mid[CR]   : 1'b0;
    assign l_b = HAS_L ? below[CL] : 1'b0;
    assign r_b = HAS_R ? below[CR] : 1'b0;

    assign n = NCNT_W'(l_a) + NCNT_W'(above[c]) + NCNT_W'(r_a)
             + NCNT_W'(l_m) + NCNT_W'(r_m)
             + NCNT_W'(l_b) + NCNT_W'(below[c]) + NCNT_W'(r_b);

    assign row_next[c] = life_rule(mid[c], n);
  end

endmodule

// File: rtl/conware_life_engine.sv
// Game of Life accelerator: loads a grid over AXI-Stream, runs N generations, streams it back.
//   state      | meaning
//   ST_LOAD    | accept one row per beat into cur; first beat latches gens, clears status
//   ST_COMPUTE | rows 0..H-1 build nxt; extra cycle copies nxt->cur and counts the generation
//   ST_SEND    | stream cur out one row per handshake, TLAST on the final row
module conware_life_engine
  import conware_pkg::*;
#(
  parameter int GRID_W            = 32,
  parameter int GRID_H            = 32,
  parameter int C_AXIS_DATA_WIDTH = 32,
  parameter int WRAP              = 1
) (
  input  logic                           ACLK,
  input  logic                           ARESETN,
  input  logic [7:0]                     CONWARE_GENS,
  output logic [7:0]                     CONWARE_BUFFER,
  output logic                           CONWARE_ERR,
  output logic                           S_AXIS_TREADY,
  input  logic [C_AXIS_DATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic                           S_AXIS_TLAST,
  input  logic                           S_AXIS_TVALID,
  output logic                           M_AXIS_TVALID,
  output logic [C_AXIS_DATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic                           M_AXIS_TLAST,
  input  logic                           M_AXIS_TREADY,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TKEEP,
  output logic [C_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB
);

  localparam int RW = $clog2(GRID_H + 1);
  localparam int IW = $clog2(GRID_H);
  localparam logic [RW-1:0] LAST_ROW = RW'(GRID_H - 1);
  localparam logic [RW-1:0] SWAP_ROW = RW'(GRID_H);
  localparam logic [IW-1:0] LAST_IDX = IW'(GRID_H - 1);

  state_e            state_q, state_d;
  logic [RW-1:0]     row_q, row_d;
  logic [7:0]        gen_left_q, gen_left_d;
  logic [7:0]        done_q, done_d;
  logic              err_q, err_d;
  logic              s_ready_q, s_ready_d;
  logic [GRID_W-1:0] cur_q [GRID_H];
  logic [GRID_W-1:0] cur_d [GRID_H];
  logic [GRID_W-1:0] nxt_q [GRID_H];
  logic [GRID_W-1:0] nxt_d [GRID_H];

  logic [IW-1:0]     mid_idx, up_idx, dn_idx;
  logic [GRID_W-1:0] row_above, row_mid, row_below, row_new;
  logic              first_beat, at_last;
  logic [7:0]        gens_eff;
  logic              unused_tdata;

  assign unused_tdata = ^S_AXIS_TDATA;

  // The swap cycle parks row_q at GRID_H; clamp so every bank read stays in range.
  always_comb begin
    mid_idx   = (row_q >= SWAP_ROW) ? '0 : IW'(row_q);
    up_idx    = (mid_idx == '0) ? LAST_IDX : mid_idx - IW'(1);
    dn_idx    = (mid_idx == LAST_IDX) ? '0 : mid_idx + IW'(1);
    row_mid   = cur_q[mid_idx];
    row_above = ((mid_idx == '0) && (WRAP == 0)) ? '0 : cur_q[up_idx];
    row_below = ((mid_idx == LAST_IDX) && (WRAP == 0)) ? '0 : cur_q[dn_idx];
  end

  conware_row_next #(
    .GRID_W (GRID_W),
    .WRAP   (WRAP != 0)
  ) u_row_next (
    .above    (row_above),
    .mid      (row_mid),
    .below    (row_below),
    .row_next (row_new)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    gen_left_d = gen_left_q;
    done_d     = done_q;
    err_d      = err_q;
    cur_d      = cur_q;
    nxt_d      = nxt_q;
    first_beat = (row_q == '0);
    at_last    = (row_q == LAST_ROW);
    gens_eff   = gen_left_q;

    case (state_q)
      ST_LOAD: begin
        if (S_AXIS_TVALID && s_ready_q) begin
          // Wiping the bank on the first beat makes a short frame read back zero-filled.
          if (first_beat) begin
            for (int i = 0; i < GRID_H; i++) cur_d[i] = '0;
            gen_left_d = CONWARE_GENS;
            gens_eff   = CONWARE_GENS;
            done_d     = '0;
            err_d      = 1'b0;
          end
          cur_d[mid_idx] = S_AXIS_TDATA[GRID_W-1:0];
          if (S_AXIS_TLAST || at_last) begin
            if (S_AXIS_TLAST != at_last) err_d = 1'b1;
            row_d   = '0;
            state_d = (gens_eff == 8'd0) ? ST_SEND : ST_COMPUTE;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end

      ST_COMPUTE: begin
        if (row_q == SWAP_ROW) begin
          cur_d      = nxt_q;
          gen_left_d = gen_left_q - 8'd1;
          done_d     = (done_q == 8'hFF) ? done_q : done_q + 8'd1;
          row_d      = '0;
          if (gen_left_q == 8'd1) state_d = ST_SEND;
        end else begin
          nxt_d[mid_idx] = row_new;
          row_d          = row_q + RW'(1);
        end
      end

      ST_SEND: begin
        if (M_AXIS_TREADY) begin
          if (at_last) begin
            row_d   = '0;
            state_d = ST_LOAD;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end

      default: state_d = ST_LOAD;
    endcase

    s_ready_d = (state_d == ST_LOAD);
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= ST_LOAD;
      row_q      <= '0;
      gen_left_q <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
      s_ready_q  <= 1'b0;
      for (int i = 0; i < GRID_H; i++) begin
        cur_q[i] <= '0;
        nxt_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      gen_left_q <= gen_left_d;
      done_q     <= done_d;
      err_q      <= err_d;
      s_ready_q  <= s_ready_d;
      cur_q      <= cur_d;
      nxt_q      <= nxt_d;
    end
  end

  assign S_AXIS_TREADY  = s_ready_q;
  assign M_AXIS_TVALID  = (state_q == ST_SEND);
  assign M_AXIS_TLAST   = M_AXIS_TVALID && (row_q == LAST_ROW);
  assign M_AXIS_TKEEP   = '1;
  assign M_AXIS_TSTRB   = '1;
  assign CONWARE_BUFFER = done_q;
  assign CONWARE_ERR    = err_q;

  always_comb begin
    M_AXIS_TDATA = '0;
    if (state_q == ST_SEND) M_AXIS_TDATA[GRID_W-1:0] = row_mid;
  end

endmodule
